// File: rtl/io_tx_fifo_port_if.sv
// Bus-side signal bundle for io_tx_fifo_port: demultiplexed 8088 IO strobes
// plus the downstream transmit byte stream. Data stays a plain inout net.
interface io_tx_fifo_port_if;
  logic [19:0] Address;
  logic        IOM;
  logic        ALE;
  logic        CS;
  logic        RD;
  logic        WR;
  logic [7:0]  q_data;
  logic        q_valid;
  logic        q_ready;

  // Peripheral side
  modport slave (
    input  Address, IOM, ALE, CS, RD, WR, q_ready,
    output q_data, q_valid
  );

  // CPU / consumer side
  modport master (
    output Address, IOM, ALE, CS, RD, WR, q_ready,
    input  q_data, q_valid
  );
endinterface

// File: rtl/io_tx_fifo_port.sv
// io_tx_fifo_port: IO-mapped transmit FIFO on the 8088 minimum-mode bus.
// OUT to reg 0 pushes a byte, OUT to reg 1 is control, IN returns status/count.
// Optional macro FIFO_IRQ_EN adds a registered irq output and control bit2.
module io_tx_fifo_port #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] PORT_BASE = 16'h0040
) (
  input  logic             CLK,
  input  logic             RESET,
  inout  wire  [7:0]       Data,
  io_tx_fifo_port_if.slave bus
`ifdef FIFO_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
`ifdef FIFO_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SEL, WRITE, READ} state_t;

  state_t             state;
  logic               reg_sel;
  logic [7:0]         wdata;
  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic               irq_en;
  logic               q_valid;
  logic [7:0]         q_data;

  logic               hit_c;
  logic               full_c;
  logic               empty_c;
  logic               commit_c;
  logic               push_req_c;
  logic               ctrl_req_c;
  logic               flush_c;
  logic               pop_c;
  logic               do_push_c;
  logic               ovf_set_c;
  logic [PTR_W-1:0]   rd_ptr_nxt_c;
  logic [PTR_W-1:0]   wr_ptr_nxt_c;
  logic [CNT_W-1:0]   count_nxt_c;
  logic               ovf_nxt_c;
  logic               irq_en_nxt_c;
  logic [7:0]         head_nxt_c;
  logic [7:0]         rdata_c;
  logic               rd_drive_c;
  logic               unused_addr;

  // IO space is 16 bits wide on the 8088; upper address lines are don't-care
  assign unused_addr = ^bus.Address[19:16];

  assign bus.q_data  = q_data;
  assign bus.q_valid = q_valid;

  // Decode, FIFO next-state and read-back mux
  always_comb begin
    hit_c        = bus.ALE && bus.CS && bus.IOM &&
                   (bus.Address[15:1] == PORT_BASE[15:1]);
    full_c       = (count == CNT_W'(DEPTH));
    empty_c      = (count == '0);
    commit_c     = (state == WRITE) && bus.WR;
    push_req_c   = commit_c && !reg_sel;
    ctrl_req_c   = commit_c && reg_sel;
    flush_c      = ctrl_req_c && wdata[0];
    pop_c        = q_valid && bus.q_ready;
    do_push_c    = push_req_c && (!full_c || pop_c);
    ovf_set_c    = push_req_c && full_c && !pop_c;
    rd_ptr_nxt_c = rd_ptr;
    wr_ptr_nxt_c = wr_ptr;
    count_nxt_c  = count;
    if (flush_c) begin
      rd_ptr_nxt_c = '0;
      wr_ptr_nxt_c = '0;
      count_nxt_c  = '0;
    end else begin
      if (pop_c)     rd_ptr_nxt_c = rd_ptr + PTR_W'(1);
      if (do_push_c) wr_ptr_nxt_c = wr_ptr + PTR_W'(1);
      count_nxt_c = count + CNT_W'(do_push_c) - CNT_W'(pop_c);
    end
    // New head bypasses the array when the pushed slot becomes the head
    head_nxt_c   = (do_push_c && !flush_c && (wr_ptr == rd_ptr_nxt_c)) ?
                   wdata : mem[rd_ptr_nxt_c];
    ovf_nxt_c    = ovf_set_c || (overflow && !(ctrl_req_c && wdata[1]));
    irq_en_nxt_c = ctrl_req_c ? (wdata[2] && HAS_IRQ) : irq_en;
    rdata_c      = reg_sel ? {4'h0, count}
                           : {full_c, empty_c, overflow, irq_en, count};
    rd_drive_c   = (state == READ) && !bus.RD;
  end

  // Data is driven only while a selected read strobe is low
  assign Data = rd_drive_c ? rdata_c : 8'bz;

  // Bus FSM, FIFO state and registered stream outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      reg_sel  <= 1'b0;
      wdata    <= 8'h00;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      q_valid  <= 1'b0;
      q_data   <= 8'h00;
`ifdef FIFO_IRQ_EN
      irq      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hit_c) begin
            state   <= SEL;
            reg_sel <= bus.Address[0];
          end
        end
        SEL: begin
          if (!bus.WR) begin
            state <= WRITE;
            wdata <= Data;
          end else if (!bus.RD) begin
            state <= READ;
          end else if (bus.ALE) begin
            state <= IDLE;
          end
        end
        WRITE: begin
          if (!bus.WR) wdata <= Data;
          else         state <= IDLE;
        end
        READ: begin
          if (bus.RD) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (do_push_c) mem[wr_ptr] <= wdata;
      rd_ptr   <= rd_ptr_nxt_c;
      wr_ptr   <= wr_ptr_nxt_c;
      count    <= count_nxt_c;
      overflow <= ovf_nxt_c;
      irq_en   <= irq_en_nxt_c;
      q_valid  <= (count_nxt_c != '0);
      q_data   <= head_nxt_c;
`ifdef FIFO_IRQ_EN
      irq      <= irq_en_nxt_c && ((count_nxt_c == '0) || ovf_nxt_c);
`endif
    end
  end

endmodule

// File: tb/tb_io_tx_fifo_port.sv
// Bench for io_tx_fifo_port: directed bus cycles plus random traffic, checked
// every cycle against a queue-based model of the FIFO and register map.
module tb_io_tx_fifo_port;
  localparam int          DEPTH     = 8;
  localparam logic [15:0] PORT_BASE = 16'h0040;
`ifdef FIFO_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  wire  [7:0] Data;
  logic       tb_drv;
  logic [7:0] tb_dout;

  assign Data = tb_drv ? tb_dout : 8'bz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (Data[i]);
  end

  io_tx_fifo_port_if bus();
`ifdef FIFO_IRQ_EN
  logic irq;
`endif

  io_tx_fifo_port #(.DEPTH(DEPTH), .PORT_BASE(PORT_BASE)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .Data  (Data),
    .bus   (bus)
`ifdef FIFO_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  always #5 CLK = ~CLK;

  // Model state
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_irq_en;
  bit         commit_pend;
  bit         commit_reg;
  logic [7:0] commit_data;
  bit         rd_window;
  bit         rd_reg;
  bit         chk_en;
  bit         rand_rdy;
  int         n_chk;
  int         n_fail;
  logic [7:0] last_rd;
  logic [7:0] drained[$];

  // Model: apply pop / committed write on each posedge
  always @(posedge CLK) begin
    bit pop;
    bit full;
    if (RESET) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_irq_en = 1'b0;
    end else begin
      pop  = (mq.size() != 0) && bus.q_ready;
      full = (mq.size() == DEPTH);
      if (commit_pend && commit_reg) begin
        if (commit_data[0]) mq.delete();
        else if (pop) void'(mq.pop_front());
        if (commit_data[1]) m_ovf = 1'b0;
        m_irq_en = HAS_IRQ && commit_data[2];
      end else begin
        if (pop) void'(mq.pop_front());
        if (commit_pend) begin
          if (!full || pop) mq.push_back(commit_data);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  function automatic logic [7:0] exp_read(input bit r1);
    int unsigned cnt;
    logic [3:0]  c;
    cnt = mq.size();
    c   = 4'(cnt);
    if (r1) return {4'h0, c};
    return {(cnt == DEPTH), (cnt == 0), m_ovf, m_irq_en, c};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle_check();
    check("q_valid", 8'(bus.q_valid), 8'(mq.size() != 0));
    if (mq.size() != 0) check("q_data", bus.q_data, mq[0]);
`ifdef FIFO_IRQ_EN
    check("irq", 8'(irq), 8'(m_irq_en && ((mq.size() == 0) || m_ovf)));
`endif
    if (rd_window) begin
      last_rd = Data;
      check("rd_data", Data, exp_read(rd_reg));
    end else if (!tb_drv) begin
      check("data_idle", Data, 8'hFF);
    end
  endtask

  // One clock: compare at negedge, then move to just after the next posedge
  task automatic step();
    @(negedge CLK);
    if (chk_en) cycle_check();
    @(posedge CLK);
    #1;
    if (rand_rdy) bus.q_ready = ($urandom_range(0, 3) == 0);
  endtask

  task automatic io_write(input logic [19:0] addr, input bit iom, input bit cs,
                          input logic [7:0] d, input int hold, input bit rdy_commit);
    bit sel;
    sel = iom && cs && (addr[15:1] == PORT_BASE[15:1]);
    bus.Address = addr; bus.IOM = iom; bus.CS = cs; bus.ALE = 1'b1;
    step();
    bus.ALE = 1'b0; bus.WR = 1'b0; tb_dout = d; tb_drv = 1'b1;
    for (int i = 0; i < hold; i++) step();
    bus.WR = 1'b1; tb_drv = 1'b0;
    if (sel) begin
      commit_pend = 1'b1; commit_reg = addr[0]; commit_data = d;
    end
    if (rdy_commit) bus.q_ready = 1'b1;
    step();
    commit_pend = 1'b0;
    if (rdy_commit) bus.q_ready = 1'b0;
    bus.CS = 1'b0; bus.IOM = 1'b0;
  endtask

  task automatic io_read(input logic [19:0] addr, input bit iom, input bit cs);
    bit sel;
    sel = iom && cs && (addr[15:1] == PORT_BASE[15:1]);
    last_rd = 8'hEE;
    bus.Address = addr; bus.IOM = iom; bus.CS = cs; bus.ALE = 1'b1;
    step();
    bus.ALE = 1'b0; bus.RD = 1'b0;
    step();
    rd_window = sel; rd_reg = addr[0];
    step();
    rd_window = 1'b0; bus.RD = 1'b1;
    step();
    bus.CS = 1'b0; bus.IOM = 1'b0;
  endtask

  task automatic drain();
    drained.delete();
    bus.q_ready = 1'b1;
    for (int i = 0; i < 20 && bus.q_valid; i++) begin
      drained.push_back(bus.q_data);
      step();
    end
    bus.q_ready = 1'b0;
    check("drain_done", 8'(bus.q_valid), 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int op;
    logic [7:0] d;
    RESET = 1'b1; tb_drv = 1'b0; tb_dout = 8'h00;
    bus.Address = '0; bus.IOM = 1'b0; bus.ALE = 1'b0; bus.CS = 1'b0;
    bus.RD = 1'b1; bus.WR = 1'b1; bus.q_ready = 1'b0;
    commit_pend = 1'b0; commit_reg = 1'b0; commit_data = 8'h00;
    rd_window = 1'b0; rd_reg = 1'b0; chk_en = 1'b0; rand_rdy = 1'b0;
    n_chk = 0; n_fail = 0; last_rd = 8'h00;
    step(); step();
    RESET = 1'b0; chk_en = 1'b1;
    check("rst_qvalid", 8'(bus.q_valid), 8'h00);
    check("rst_qdata", bus.q_data, 8'h00);
    check("rst_data", Data, 8'hFF);

    // Reset in the middle of a write: nothing is pushed
    bus.Address = 20'h00040; bus.IOM = 1'b1; bus.CS = 1'b1; bus.ALE = 1'b1;
    step();
    bus.ALE = 1'b0; bus.WR = 1'b0; tb_dout = 8'hA5; tb_drv = 1'b1;
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0; bus.WR = 1'b1; tb_drv = 1'b0; bus.CS = 1'b0; bus.IOM = 1'b0;
    step();
    check("rstw_qvalid", 8'(bus.q_valid), 8'h00);
    check("rstw_data", Data, 8'hFF);
    io_read(20'h00040, 1'b1, 1'b1);
    check("rstw_status", last_rd, 8'h40);

    // Three pushes, status/count, then drain in order
    io_write(20'h00040, 1'b1, 1'b1, 8'h11, 2, 1'b0);
    io_write(20'h00040, 1'b1, 1'b1, 8'h22, 1, 1'b0);
    io_write(20'h00040, 1'b1, 1'b1, 8'h33, 3, 1'b0);
    io_read(20'h00040, 1'b1, 1'b1);
    check("stat3", last_rd, 8'h03);
    io_read(20'h00041, 1'b1, 1'b1);
    check("cnt3", last_rd, 8'h03);
    drain();
    check("drain3_n", 8'(drained.size()), 8'd3);
    check("drain3_0", drained[0], 8'h11);
    check("drain3_1", drained[1], 8'h22);
    check("drain3_2", drained[2], 8'h33);
    io_read(20'h00040, 1'b1, 1'b1);
    check("stat_empty", last_rd, 8'h40);

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) io_write(20'h00040, 1'b1, 1'b1, 8'(i), 1, 1'b0);
    io_read(20'h00040, 1'b1, 1'b1);
    check("stat_ovf", last_rd, 8'hA8);
    drain();
    check("ovf_drain_n", 8'(drained.size()), 8'd8);
    for (int i = 0; i < 8; i++) check("ovf_drain_i", drained[i], 8'(i));
    io_read(20'h00040, 1'b1, 1'b1);
    check("stat_ovf_empty", last_rd, 8'h60);
    io_write(20'h00041, 1'b1, 1'b1, 8'h02, 1, 1'b0);
    io_read(20'h00040, 1'b1, 1'b1);
    check("stat_ovf_clr", last_rd, 8'h40);

    // Full with a same-cycle pop: both happen, no overflow
    for (int i = 0; i < 8; i++) io_write(20'h00040, 1'b1, 1'b1, 8'(8'h80 + i), 1, 1'b0);
    io_write(20'h00040, 1'b1, 1'b1, 8'hC8, 2, 1'b1);
    io_read(20'h00040, 1'b1, 1'b1);
    check("stat_fullpop", last_rd, 8'h88);
    drain();
    check("fp_n", 8'(drained.size()), 8'd8);
    check("fp_first", drained[0], 8'h81);
    check("fp_last", drained[7], 8'hC8);

    // Flush with five entries
    for (int i = 0; i < 5; i++) io_write(20'h00040, 1'b1, 1'b1, 8'(8'h50 + i), 1, 1'b0);
    io_write(20'h00041, 1'b1, 1'b1, 8'h01, 1, 1'b0);
    check("flush_qvalid", 8'(bus.q_valid), 8'h00);
    io_read(20'h00041, 1'b1, 1'b1);
    check("flush_cnt", last_rd, 8'h00);

    // Interrupt enable
`ifdef FIFO_IRQ_EN
    io_write(20'h00041, 1'b1, 1'b1, 8'h04, 1, 1'b0);
    check("irq_empty", 8'(irq), 8'h01);
    io_read(20'h00040, 1'b1, 1'b1);
    check("stat_irq", last_rd, 8'h50);
    io_write(20'h00040, 1'b1, 1'b1, 8'h5A, 1, 1'b0);
    check("irq_busy", 8'(irq), 8'h00);
    drain();
    check("irq_drained", 8'(irq), 8'h01);
    io_write(20'h00041, 1'b1, 1'b1, 8'h00, 1, 1'b0);
    check("irq_off", 8'(irq), 8'h00);
`else
    io_write(20'h00041, 1'b1, 1'b1, 8'h04, 1, 1'b0);
    io_read(20'h00040, 1'b1, 1'b1);
    check("stat_noirq", last_rd, 8'h40);
`endif

    // Cycles not addressed to this port
    io_write(20'h00042, 1'b1, 1'b1, 8'h77, 1, 1'b0);
    io_write(20'h00040, 1'b0, 1'b1, 8'h78, 1, 1'b0);
    io_write(20'h00040, 1'b1, 1'b0, 8'h79, 1, 1'b0);
    check("nosel_qvalid", 8'(bus.q_valid), 8'h00);
    io_read(20'h00042, 1'b1, 1'b1);
    io_read(20'h00040, 1'b0, 1'b1);
    io_read(20'h00040, 1'b1, 1'b0);
    io_read(20'h00040, 1'b1, 1'b1);
    check("nosel_status", last_rd, 8'h40);

    // Random traffic
    rand_rdy = 1'b1;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      d  = 8'($urandom);
      case (op)
        0, 1, 2, 3, 4: io_write(20'h00040, 1'b1, 1'b1, d, $urandom_range(1, 3), 1'b0);
        5: begin
          d[0] = ($urandom_range(0, 3) == 0);
          io_write(20'h00041, 1'b1, 1'b1, d, $urandom_range(1, 2), 1'b0);
        end
        6: io_read(20'h00040, 1'b1, 1'b1);
        7: io_read(20'h00041, 1'b1, 1'b1);
        8: begin
          case ($urandom_range(0, 2))
            0: io_write(20'h00042, 1'b1, 1'b1, d, 1, 1'b0);
            1: io_write(20'h00040, 1'b0, 1'b1, d, 1, 1'b0);
            default: io_read(20'h00041, 1'b1, 1'b0);
          endcase
        end
        default: begin
          bus.Address = 20'h00040; bus.IOM = 1'b1; bus.CS = 1'b1; bus.ALE = 1'b1;
          step();
          bus.Address = 20'h01234;
          step();
          bus.ALE = 1'b0; bus.CS = 1'b0; bus.IOM = 1'b0;
          step();
        end
      endcase
    end
    rand_rdy = 1'b0;
    bus.q_ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
